// File: rtl/alu_pkg.sv
// alu_pkg: opcode / funct3 encodings shared by the execute unit and its
// branch comparator. Mirrors the decoder/RS encodings so all agree.
package alu_pkg;

  // RV32 major opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_branch_cmp.sv
// branch_cmp: combinational branch condition evaluator.
//   a, b   : rs1 / rs2 values
//   func3  : branch funct3
//   taken  : condition holds; reserved encodings (010/011) are not taken
module branch_cmp
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        func3,
  output logic              taken
);

  logic eq, lt_s, lt_u;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    unique case (func3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: single-issue integer execute unit. Computes rd value, branch outcome
// and the correct next PC for one RV32I/RV32C op per cycle and broadcasts it
// on the ALU CDB one cycle later.
//   clk, rst (async, active-low), rdy (global enable), rollback (flush)
//   exe_*  : issued operation (opcode, funct3, bit30, operands, imm, offset,
//            pc, destination ROB tag, compressed flag)
//   alu_*  : registered broadcast (valid, rob id, data, jump, real pc)
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                exe_valid,
  input  logic [6:0]          exe_opcode,
  input  logic [2:0]          exe_func3,
  input  logic                exe_func1,
  input  logic [DATA_W-1:0]   exe_data1,
  input  logic [DATA_W-1:0]   exe_data2,
  input  logic [DATA_W-1:0]   exe_imm,
  input  logic [DATA_W-1:0]   exe_off,
  input  logic [DATA_W-1:0]   exe_pc,
  input  logic [ROB_ID_W-1:0] exe_rob_target,
  input  logic                exe_is_c_extend,
  output logic                alu_valid,
  output logic [ROB_ID_W-1:0] alu_rob_id,
  output logic [DATA_W-1:0]   alu_data,
  output logic                alu_jump,
  output logic [DATA_W-1:0]   alu_real_pc
);

  localparam int SH_W = $clog2(DATA_W);

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   data;
    logic                jump;
    logic [DATA_W-1:0]   real_pc;
  } res_t;

  res_t res_d, res_q;
  logic valid_q;

  logic [DATA_W-1:0] snpc, op_b, br_tgt;
  logic [SH_W-1:0]   shamt;
  logic              br_taken, is_reg;

  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a     (exe_data1),
    .b     (exe_data2),
    .func3 (exe_func3),
    .taken (br_taken)
  );

  assign is_reg = (exe_opcode == OP_REG);
  assign snpc   = exe_pc + (exe_is_c_extend ? DATA_W'(2) : DATA_W'(4));
  assign br_tgt = exe_pc + exe_off;
  assign op_b   = is_reg ? exe_data2 : exe_imm;
  assign shamt  = op_b[SH_W-1:0];

  always_comb begin
    res_d         = '0;
    res_d.rob_id  = exe_rob_target;
    res_d.real_pc = snpc;
    unique case (exe_opcode)
      OP_LUI:   res_d.data = exe_imm;
      OP_AUIPC: res_d.data = exe_pc + exe_imm;
      OP_JAL: begin
        res_d.data    = snpc;
        res_d.jump    = 1'b1;
        res_d.real_pc = br_tgt;
      end
      OP_JALR: begin
        res_d.data    = snpc;
        res_d.jump    = 1'b1;
        res_d.real_pc = (exe_data1 + exe_imm) & ~DATA_W'(1);
      end
      OP_BR: begin
        if (br_taken) begin
          res_d.jump    = 1'b1;
          res_d.real_pc = br_tgt;
        end
      end
      OP_IMM, OP_REG: begin
        unique case (exe_func3)
          // bit30 only means SUB for register ops; ADDI's imm may set it
          F3_ADD:  res_d.data = (is_reg && exe_func1) ? exe_data1 - op_b
                                                      : exe_data1 + op_b;
          F3_SLL:  res_d.data = exe_data1 << shamt;
          F3_SLT:  res_d.data = DATA_W'($signed(exe_data1) < $signed(op_b));
          F3_SLTU: res_d.data = DATA_W'(exe_data1 < op_b);
          F3_XOR:  res_d.data = exe_data1 ^ op_b;
          F3_SR:   res_d.data = exe_func1 ? DATA_W'($signed(exe_data1) >>> shamt)
                                          : exe_data1 >> shamt;
          F3_OR:   res_d.data = exe_data1 | op_b;
          F3_AND:  res_d.data = exe_data1 & op_b;
          default: res_d.data = '0;
        endcase
      end
      // unknown opcodes still broadcast so the ROB entry can retire
      default: ;
    endcase
  end

  // Rollback outranks rdy; result fields only load on a real issue so they
  // hold stale values while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (rollback) begin
      valid_q <= 1'b0;
    end else if (rdy) begin
      valid_q <= exe_valid;
      if (exe_valid) res_q <= res_d;
    end
  end

  assign alu_valid   = valid_q;
  assign alu_rob_id  = res_q.rob_id;
  assign alu_data    = res_q.data;
  assign alu_jump    = res_q.jump;
  assign alu_real_pc = res_q.real_pc;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int W = 32;
  localparam int R = 4;

  logic         clk = 0, rst = 0, rdy = 1, rollback = 0, exe_valid = 0;
  logic [6:0]   exe_opcode = 0;
  logic [2:0]   exe_func3 = 0;
  logic         exe_func1 = 0, exe_is_c_extend = 0;
  logic [W-1:0] exe_data1 = 0, exe_data2 = 0, exe_imm = 0, exe_off = 0, exe_pc = 0;
  logic [R-1:0] exe_rob_target = 0;
  logic         alu_valid, alu_jump;
  logic [R-1:0] alu_rob_id;
  logic [W-1:0] alu_data, alu_real_pc;

  int n_chk = 0, n_fail = 0;

  alu #(.DATA_W(W), .ROB_ID_W(R)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .exe_valid(exe_valid),
    .exe_opcode(exe_opcode), .exe_func3(exe_func3), .exe_func1(exe_func1),
    .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_imm(exe_imm),
    .exe_off(exe_off), .exe_pc(exe_pc), .exe_rob_target(exe_rob_target),
    .exe_is_c_extend(exe_is_c_extend), .alu_valid(alu_valid),
    .alu_rob_id(alu_rob_id), .alu_data(alu_data), .alu_jump(alu_jump),
    .alu_real_pc(alu_real_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   opc;
    logic [2:0]   f3;
    logic         f1;
    logic [W-1:0] d1, d2, imm, off, pc;
    logic [R-1:0] tag;
    logic         c;
  } op_t;

  typedef logic [1+R+W+1+W-1:0] obs_t;

  function automatic op_t mk(logic [6:0] opc, logic [2:0] f3, logic f1,
                             logic [W-1:0] d1, logic [W-1:0] d2, logic [W-1:0] imm,
                             logic [W-1:0] off, logic [W-1:0] pc, logic [R-1:0] tag,
                             logic c);
    op_t o;
    o.opc = opc; o.f3 = f3; o.f1 = f1; o.d1 = d1; o.d2 = d2; o.imm = imm;
    o.off = off; o.pc = pc; o.tag = tag; o.c = c;
    return o;
  endfunction

  // Reference: instruction semantics from the ISA rules, returned as the
  // packed broadcast {valid, tag, data, jump, real_pc}.
  function automatic obs_t model(op_t o);
    logic [W-1:0] snpc, data, rpc, a, b;
    logic         j;
    int           sh;
    snpc = o.pc + (o.c ? 2 : 4);
    data = 0; j = 0; rpc = snpc;
    a = o.d1;
    case (o.opc)
      7'b0110111: data = o.imm;
      7'b0010111: data = o.pc + o.imm;
      7'b1101111: begin data = snpc; j = 1; rpc = o.pc + o.off; end
      7'b1100111: begin data = snpc; j = 1; rpc = (o.d1 + o.imm) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (o.f3)
          3'd0: j = (o.d1 == o.d2);
          3'd1: j = (o.d1 != o.d2);
          3'd4: j = ($signed(o.d1) <  $signed(o.d2));
          3'd5: j = ($signed(o.d1) >= $signed(o.d2));
          3'd6: j = (o.d1 <  o.d2);
          3'd7: j = (o.d1 >= o.d2);
          default: j = 0;
        endcase
        if (j) rpc = o.pc + o.off;
      end
      7'b0010011, 7'b0110011: begin
        b  = (o.opc == 7'b0110011) ? o.d2 : o.imm;
        sh = int'(b % 32);
        case (o.f3)
          3'd0: data = (o.opc == 7'b0110011 && o.f1) ? a - b : a + b;
          3'd1: data = a << sh;
          3'd2: data = ($signed(a) < $signed(b)) ? 1 : 0;
          3'd3: data = (a < b) ? 1 : 0;
          3'd4: data = a ^ b;
          3'd5: data = !o.f1 ? (a >> sh) : (a[31] ? ~((~a) >> sh) : (a >> sh));
          3'd6: data = a | b;
          default: data = a & b;
        endcase
      end
      default: ;
    endcase
    return {1'b1, o.tag, data, j, rpc};
  endfunction

  function automatic obs_t obs();
    return {alu_valid, alu_rob_id, alu_data, alu_jump, alu_real_pc};
  endfunction

  task automatic drive(op_t o, logic v);
    exe_valid = v; exe_opcode = o.opc; exe_func3 = o.f3; exe_func1 = o.f1;
    exe_data1 = o.d1; exe_data2 = o.d2; exe_imm = o.imm; exe_off = o.off;
    exe_pc = o.pc; exe_rob_target = o.tag; exe_is_c_extend = o.c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs());
    end
    @(negedge clk); rst = 1;
    tick();
    n_chk++;
    if (alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: valid got %b want 0", alu_valid);
    end
  endtask

  task automatic test_add_sub();
    op_t o;
    for (int s = 0; s < 2; s++) begin
      o = mk(7'b0110011, 3'd0, s[0], 7, 9, 0, 0, 32'h40, 3, 0);
      drive(o, 1); tick();
      n_chk++;
      if (obs() !== {1'b1, 4'd3, (s == 0 ? 32'd16 : 32'hFFFF_FFFE), 1'b0, 32'h44}) begin
        n_fail++; $display("FAIL add_sub[%0d]: got %h want data %h", s, obs(), (s == 0 ? 32'd16 : 32'hFFFF_FFFE));
      end
    end
  endtask

  task automatic test_shifts();
    logic [W-1:0] want [3];
    op_t          ops  [3];
    ops[0] = mk(7'b0010011, 3'd5, 1, 32'h8000_0000, 0, 32'h404, 0, 0, 5, 0);
    ops[1] = mk(7'b0010011, 3'd5, 0, 32'h8000_0000, 0, 32'h004, 0, 0, 6, 0);
    ops[2] = mk(7'b0010011, 3'd3, 1, 32'h1, 0, 32'hFFFF_FFFF, 0, 0, 7, 0);
    want[0] = 32'hF800_0000; want[1] = 32'h0800_0000; want[2] = 32'h1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1); tick();
      n_chk++;
      if (alu_data !== want[i] || alu_rob_id !== ops[i].tag || alu_valid !== 1'b1) begin
        n_fail++; $display("FAIL shift_sltiu[%0d]: got data %h want %h", i, alu_data, want[i]);
      end
    end
  endtask

  task automatic test_branches();
    // BLT taken, BLTU not taken on the same operands
    drive(mk(7'b1100011, 3'd4, 0, 32'hFFFF_FFFF, 1, 0, 32'h20, 32'h100, 8, 0), 1); tick();
    n_chk++;
    if (alu_jump !== 1'b1 || alu_real_pc !== 32'h120 || alu_data !== 0) begin
      n_fail++; $display("FAIL blt: got jump %b pc %h want 1 00000120", alu_jump, alu_real_pc);
    end
    drive(mk(7'b1100011, 3'd6, 0, 32'hFFFF_FFFF, 1, 0, 32'h20, 32'h100, 9, 0), 1); tick();
    n_chk++;
    if (alu_jump !== 1'b0 || alu_real_pc !== 32'h104) begin
      n_fail++; $display("FAIL bltu: got jump %b pc %h want 0 00000104", alu_jump, alu_real_pc);
    end
    // reserved funct3 on equal operands is never taken
    drive(mk(7'b1100011, 3'd2, 0, 5, 5, 0, 32'h40, 32'h100, 10, 1), 1); tick();
    n_chk++;
    if (alu_jump !== 1'b0 || alu_real_pc !== 32'h102) begin
      n_fail++; $display("FAIL br_reserved: got jump %b pc %h want 0 00000102", alu_jump, alu_real_pc);
    end
  endtask

  task automatic test_c_jalr();
    drive(mk(7'b1100111, 3'd0, 0, 32'h1235, 0, 0, 0, 32'h200, 11, 1), 1); tick();
    n_chk++;
    if (obs() !== {1'b1, 4'd11, 32'h202, 1'b1, 32'h1234}) begin
      n_fail++; $display("FAIL c_jalr: got %h want data 202 jump 1 pc 1234", obs());
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 1; t <= 3; t++) begin
      drive(mk(7'b0010011, 3'd0, 0, t * 100, 0, 1, 0, 0, t[R-1:0], 0), 1); tick();
      n_chk++;
      if (alu_valid !== 1'b1 || alu_rob_id !== t[R-1:0] || alu_data !== t * 100 + 1) begin
        n_fail++; $display("FAIL b2b[%0d]: got v %b tag %0d data %0d", t, alu_valid, alu_rob_id, alu_data);
      end
    end
    exe_valid = 0; tick();
    n_chk++;
    if (alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_drop: valid got %b want 0", alu_valid);
    end
  endtask

  task automatic test_rollback();
    drive(mk(7'b0010011, 3'd0, 0, 1, 0, 1, 0, 0, 2, 0), 1); tick();
    drive(mk(7'b0010011, 3'd0, 0, 1, 0, 2, 0, 0, 3, 0), 1); rollback = 1; tick();
    n_chk++;
    if (alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL rollback: valid got %b want 0", alu_valid);
    end
    rollback = 0; exe_valid = 0; tick();
  endtask

  task automatic test_async_reset();
    drive(mk(7'b0110111, 3'd0, 0, 0, 0, 32'hABCD_0000, 0, 32'h300, 12, 0), 1); tick();
    n_chk++;
    if (alu_valid !== 1'b1 || alu_data !== 32'hABCD_0000) begin
      n_fail++; $display("FAIL lui_pre_reset: got v %b data %h", alu_valid, alu_data);
    end
    #2 rst = 0; #1;
    n_chk++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", obs());
    end
    exe_valid = 0;
    @(negedge clk); rst = 1; tick();
  endtask

  task automatic test_rdy_hold();
    obs_t held;
    drive(mk(7'b0010111, 3'd0, 0, 0, 0, 32'h10, 0, 32'h500, 13, 0), 1); tick();
    held = {1'b1, 4'd13, 32'h510, 1'b0, 32'h504};
    n_chk++;
    if (obs() !== held) begin
      n_fail++; $display("FAIL auipc: got %h want %h", obs(), held);
    end
    rdy = 0;
    drive(mk(7'b1101111, 3'd0, 0, 0, 0, 0, 32'h80, 32'h600, 14, 0), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (obs() !== held) begin
        n_fail++; $display("FAIL rdy_hold[%0d]: got %h want %h", i, obs(), held);
      end
    end
    rollback = 1; tick();
    n_chk++;
    if (alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL rollback_over_rdy: valid got %b want 0", alu_valid);
    end
    rollback = 0; rdy = 1; tick();
    n_chk++;
    if (obs() !== model(mk(7'b1101111, 3'd0, 0, 0, 0, 0, 32'h80, 32'h600, 14, 0))) begin
      n_fail++; $display("FAIL jal_after_rdy: got %h", obs());
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [8];
    op_t o;
    obs_t want;
    opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
             7'b1100011, 7'b0010011, 7'b0110011, 7'b0000011};
    for (int i = 0; i < 400; i++) begin
      o = mk(opcs[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom, R'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) o.d2 = o.d1;
      if ($urandom_range(0, 3) == 0) o.d1 = $urandom_range(0, 3);
      drive(o, 1); tick();
      want = model(o);
      n_chk++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL random[%0d] opc %b f3 %0d f1 %b: got %h want %h", i, o.opc, o.f3, o.f1, obs(), want);
      end
    end
    exe_valid = 0; tick();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_branches();
    test_c_jalr();
    test_back_to_back();
    test_rollback();
    test_async_reset();
    test_rdy_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-issue integer execute unit downstream of the reservation station. Accepts at most one ready RV32I/RV32C operation per cycle from the `exe_*` bus and computes the result, branch outcome and actual next PC. Broadcasts the result one cycle later on the ALU common-data bus (`alu_*`), which feeds the RS, LSB and ROB. Flushes its in-flight result on `rollback`.

## Interface
- `DATA_W`, default 32: operand, result and PC width.
- `ROB_ID_W`, default 4: ROB tag width; must match `ROB_ID_WID` in const.v.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `rdy` input 1: global enable; when low, all state holds.
- `rollback` input 1: mispredict flush from the ROB.
- `exe_valid` input 1: an operation is presented this cycle.
- `exe_opcode` input 7: RV32 major opcode.
- `exe_func3` input 3: funct3.
- `exe_func1` input 1: instruction bit 30 (SUB/SRA/SRAI select).
- `exe_data1`, `exe_data2` input DATA_W: rs1 and rs2 values.
- `exe_imm` input DATA_W: sign-extended I/U immediate.
- `exe_off` input DATA_W: sign-extended B/J offset.
- `exe_pc` input DATA_W: instruction PC.
- `exe_rob_target` input ROB_ID_W: destination ROB tag.
- `exe_is_c_extend` input 1: instruction is 16-bit compressed.
- `alu_valid` output 1: result broadcast valid.
- `alu_rob_id` output ROB_ID_W: tag of the broadcast result.
- `alu_data` output DATA_W: rd value.
- `alu_jump` output 1: control transfer is taken (JAL, JALR, or a taken branch).
- `alu_real_pc` output DATA_W: architecturally correct next PC.

## Operation
- Sequential PC `snpc = exe_pc + (exe_is_c_extend ? 2 : 4)`.
- LUI 0110111: `data = imm`, `jump = 0`, `real_pc = snpc`.
- AUIPC 0010111: `data = pc + imm`.
- JAL 1101111: `data = snpc`, `jump = 1`, `real_pc = pc + off`.
- JALR 1100111: `data = snpc`, `jump = 1`, `real_pc = (data1 + imm) & ~1`.
- BRANCH 1100011: func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. `data = 0`. If taken: `real_pc = pc + off`, `jump = 1`. Otherwise `real_pc = snpc`, `jump = 0`. Func3 010/011 count as not taken.
- OP-IMM 0010011: operand b = imm. ADDI, SLTI, SLTIU, XORI, ORI, ANDI. SLLI and SRLI/SRAI use `imm[4:0]`; `func1` selects SRAI.
- OP 0110011: operand b = data2. `func1` selects SUB over ADD and SRA over SRL. Shift amount is `data2[4:0]`. SLT/SLTU results are zero-extended to 0 or 1.
- All arithmetic is modulo 2^DATA_W. Signed compares use two's complement.
- Any other opcode: `alu_valid` is still asserted with `data = 0`, `jump = 0`, `real_pc = snpc`, so that the ROB entry retires.
- Unused outputs of non-jump ops: `jump = 0`, `real_pc = snpc`.

## Timing
- Reset values: `alu_valid = 0`, `alu_rob_id = 0`, `alu_data = 0`, `alu_jump = 0`, `alu_real_pc = 0`. Reset applies immediately, independent of `clk` and `rdy`.
- Latency is 1 cycle. `exe_valid` sampled at edge N gives `alu_valid = 1` with the result during cycle N+1.
- Throughput is 1 per cycle. There is no backpressure; the RS issues blindly.
- If `exe_valid = 0` at an edge (with `rdy = 1`), `alu_valid` goes to 0 at that edge. The data outputs may hold stale values.
- If `rollback = 1` at an edge, `alu_valid` goes to 0 regardless of `exe_valid`. Rollback has priority over `rdy`.
- If `rdy = 0` at an edge with no rollback, every output register holds its value.
- Reset asserted in the middle of an operation drops the pending result. There is no replay.

## Structure
- Opcode constants (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BR`, `OP_IMM`, `OP_REG`) and funct3 encodings live in const.v, shared with the decoder and RS.
- `DATA_WID` and `ROB_ID_WID` come from const.v.
- One sub-module: `branch_cmp`. It is combinational, takes `a`, `b`, `func3` and produces `taken`.
- All datapath logic sits in one `always @(*)` block feeding a single registered output stage.

## Test plan
- ADD then SUB: `data1 = 7`, `data2 = 9`, `func1 = 0`, tag 3 → next cycle `alu_valid = 1`, `alu_rob_id = 3`, `alu_data = 16`. Repeat with `func1 = 1` → `alu_data = 0xFFFFFFFE`.
- SRAI vs SRLI with `data1 = 0x80000000`, `imm[4:0] = 4` → SRAI gives `0xF8000000`, SRLI gives `0x08000000`. SLTIU with `data1 = 1`, `imm = 0xFFFFFFFF` → 1.
- BLT with `data1 = 0xFFFFFFFF`, `data2 = 1`, `pc = 0x100`, `off = 0x20` → `jump = 1`, `real_pc = 0x120`. BLTU with the same operands → `jump = 0`, `real_pc = 0x104`.
- C.JALR with `is_c_extend = 1`, `pc = 0x200`, `data1 = 0x1235`, `imm = 0` → `alu_data = 0x202`, `jump = 1`, `real_pc = 0x1234`.
- Back-to-back issue of tags 1, 2, 3 on consecutive cycles → broadcasts on the three following cycles. Assert `rollback` with tag 3 presented → `alu_valid = 0` on the next cycle.
- Assert `rst` low asynchronously while `alu_valid = 1` → outputs read 0 before the next edge. Hold `rdy = 0` for 2 cycles → outputs frozen.
